fir_filter_mac: RTL
===================

Name: fir_filter_mac

Overview:
- Parametrised successor to the fixed 4-tap FIR: TAPS-tap signed FIR with run-time programmable coefficients.
- Uses one time-multiplexed multiply-accumulate unit, valid/ready streaming handshake on input and output, rounding, and output saturation.
- Sits between the sample source (ADC/sensor front end) and downstream IoT processing stages that apply backpressure.

Parameters:
- DATA_W, 16, signed input/output sample width.
- COEF_W, 16, signed coefficient width.
- TAPS, 8, number of taps (≥2).
- FRAC_BITS, 0, fractional bits in coefficients; result shifted right by this amount (0 ≤ FRAC_BITS < COEF_W).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: zero delay line, abort any operation.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  DATA_W  signed filtered sample.
- out_sat  out  1  out_data was saturated (qualified by out_valid).
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  coefficient index.
- coef_wdata  in  COEF_W  signed coefficient value.
- busy  out  1  high in MAC state.

Behaviour:
- One clock domain; reset_n asynchronous assert, synchronous deassert handled upstream.
- Reset values:
  - state IDLE; in_ready=1; out_valid=0; out_data=0; out_sat=0; busy=0.
  - Delay line all zero; accumulator 0.
  - coef[0]=1<<FRAC_BITS, all other coefficients 0 (identity filter).
- Accumulator width ACC_W = DATA_W+COEF_W+clog2(TAPS); full-precision signed products; no overflow possible inside the accumulator.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready: sample[k]<=sample[k-1] for k=TAPS-1..1; sample[0]<=in_data; acc<=0; k<=0; go to MAC.
  - MAC:
    - busy=1, in_ready=0.
    - Each cycle: acc += sample[k]*coef[k]; k++.
    - Exactly TAPS cycles.
    - On the TAPS-th edge, register the final result into out_data/out_sat, set out_valid=1, go to OUT.
  - OUT:
    - in_ready=0; out_valid=1; out_data and out_sat held stable.
    - On out_ready: out_valid<=0, go to IDLE.
- Latency and throughput:
  - out_valid rises on the TAPS-th rising edge after the accepting edge.
  - Throughput with out_ready=1 is one sample per TAPS+2 cycles.
- Result formation (on the final MAC edge):
  - Let s = acc + last product.
  - If FRAC_BITS>0: s += 1<<(FRAC_BITS-1) (round half up), then arithmetic shift right by FRAC_BITS.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat=1 if clamped.
- Coefficient writes:
  - Accepted in IDLE and OUT; take effect from the next edge.
  - coef_we during MAC is ignored (no partial coefficient sets within one output).
  - coef_addr ≥ TAPS is ignored.
  - coef_we coincident with a sample accept in IDLE: write is applied, and the new value is used by that sample's MAC.
- clear:
  - In any state: delay line and acc zeroed, out_valid<=0, state<=IDLE.
  - Coefficients preserved.
  - Overrides a simultaneous in_valid (sample dropped) and out_ready.
- Backpressure: in OUT with out_ready=0, hold indefinitely; out_data must not change.
- reset_n mid-operation:
  - Immediate return to reset values, including identity coefficients.
  - No output is produced for the aborted sample.

Test Plan:
- Identity after reset: in 100, then -5 (out_ready=1) -> out_data 100, then -5; out_sat=0; out_valid first rises TAPS(8) edges after accept.
- Impulse response: write coefs {3,7,7,3,0,0,0,0}; feed 1,0,0,0,0,0,0,0 -> outputs 3,7,7,3,0,0,0,0.
- Saturation:
  - All coefs 32767; feed 32767 eight times -> 8th output 32767, out_sat=1.
  - Then all coefs 32767 with inputs -32768 -> -32768, out_sat=1.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data, out_valid stable, in_ready=0, in_valid ignored; out_ready=1 -> single handshake, in_ready=1 next cycle.
- Rounding (FRAC_BITS=2 instance):
  - coef0=4 -> input 9 gives 9.
  - coef0=2 -> input 3 gives 2, input -3 gives -1.
- Abort:
  - clear asserted mid-MAC -> out_valid stays 0, next sample 10 with identity coefs gives 10 (delay line zero), coefs retained.
  - reset_n low mid-MAC -> coefs revert to identity, all outputs at reset values.
  - coef_we during MAC -> no change to coefficients.

Source files
------------

// File: rtl/fir_filter_mac.sv
`default_nettype none
// ============================================================================
//  Module      : fir_filter_mac
//  Description : TAPS-tap signed FIR filter built around one time-multiplexed
//                multiply-accumulate unit. Coefficients can be written at run
//                time. Input and output use valid/ready handshakes. The result
//                is rounded (half up) and saturated to DATA_W bits.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   rising-edge clock
//    reset_n     in   asynchronous active-low reset
//    clear       in   synchronous flush of delay line / current operation
//    in_valid    in   input sample valid
//    in_ready    out  block can accept a sample (IDLE)
//    in_data     in   signed input sample
//    out_valid   out  filtered sample valid (OUT)
//    out_ready   in   downstream accepts the output
//    out_data    out  signed filtered sample
//    out_sat     out  out_data was clamped
//    coef_we     in   coefficient write strobe
//    coef_addr   in   coefficient index
//    coef_wdata  in   signed coefficient value
//    busy        out  MAC in progress
// ============================================================================
module fir_filter_mac #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 8,
    parameter int FRAC_BITS = 0,
    localparam int ADDR_W   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    output logic              busy
);

    localparam int PROD_W = DATA_W + COEF_W;
    // clog2(TAPS) guard bits keep the sum of TAPS full products from overflowing.
    localparam int ACC_W  = PROD_W + ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [COEF_W-1:0]       COEF_ONE  = COEF_W'(1) << FRAC_BITS;
    localparam logic [ADDR_W:0]         TAPS_CNT  = (ADDR_W+1)'(TAPS);
    localparam logic [ADDR_W-1:0]       LAST_K    = ADDR_W'(TAPS - 1);

    logic [1:0]                r_state;
    logic [1:0]                w_next;
    logic signed [DATA_W-1:0]  r_samples [TAPS];
    logic signed [COEF_W-1:0]  r_coef    [TAPS];
    logic signed [ACC_W-1:0]   r_acc;
    logic [ADDR_W-1:0]         r_k;
    logic [DATA_W-1:0]         r_out_data;
    logic                      r_out_sat;

    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_shift;
    logic                      w_last;
    logic                      w_coef_wr;
    logic                      w_sat_hi;
    logic                      w_sat_lo;
    logic [DATA_W-1:0]         w_res;

    // ------------------------------------------------------------------
    // MAC datapath and result formation
    // ------------------------------------------------------------------
    assign w_prod = r_samples[r_k] * r_coef[r_k];
    assign w_sum  = r_acc + {{ADDR_W{w_prod[PROD_W-1]}}, w_prod};
    assign w_last = (r_k == LAST_K);

    generate
        if (FRAC_BITS > 0) begin : g_round
            localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_BITS - 1);
            logic signed [ACC_W-1:0] w_round;
            assign w_round = w_sum + HALF;
            assign w_shift = w_round >>> FRAC_BITS;
        end else begin : g_no_round
            assign w_shift = w_sum;
        end
    endgenerate

    assign w_sat_hi = (w_shift > SAT_MAX);
    assign w_sat_lo = (w_shift < SAT_MIN);
    assign w_res    = w_sat_hi ? SAT_MAX[DATA_W-1:0] :
                      w_sat_lo ? SAT_MIN[DATA_W-1:0] :
                                 w_shift[DATA_W-1:0];

    // Coefficients are frozen during MAC so one output never mixes two sets.
    assign w_coef_wr = coef_we && (r_state != S_MAC) &&
                       ({1'b0, coef_addr} < TAPS_CNT);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_MAC;
            S_MAC:   if (w_last)    w_next = S_OUT;
            S_OUT:   if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
        if (clear) begin
            w_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_MAC:   busy      = 1'b1;
            S_OUT:   out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Delay line, accumulator, tap counter, output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_samples[i] <= '0;
            end
            r_acc      <= '0;
            r_k        <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < TAPS; i++) begin
                r_samples[i] <= '0;
            end
            r_acc <= '0;
            r_k   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = TAPS - 1; i > 0; i--) begin
                            r_samples[i] <= r_samples[i-1];
                        end
                        r_samples[0] <= in_data;
                        r_acc        <= '0;
                        r_k          <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= w_sum;
                    r_k   <= r_k + 1'b1;
                    if (w_last) begin
                        r_out_data <= w_res;
                        r_out_sat  <= w_sat_hi | w_sat_lo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Coefficient bank; clear leaves it untouched, reset restores identity
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_coef[i] <= '0;
            end
            r_coef[0] <= COEF_ONE;
        end else if (w_coef_wr) begin
            r_coef[coef_addr] <= coef_wdata;
        end
    end

    assign out_data = r_out_data;
    assign out_sat  = r_out_sat;

endmodule
`default_nettype wire
